// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - parametrised 2-read/2-write register file with registered reads and write acks
// Optional feature macro: RD_BYPASS_EN (defined: write-first reads; undefined: read-first reads)
module register_file_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RD_addr1,
  input  logic              RD_en1,
  input  logic [ADDR_W-1:0] RD_addr2,
  input  logic              RD_en2,
  input  logic [ADDR_W-1:0] WR_addr0,
  input  logic              WR_en0,
  input  logic [DATA_W-1:0] WR_data0,
  input  logic [ADDR_W-1:0] WR_addr1,
  input  logic              WR_en1,
  input  logic [DATA_W-1:0] WR_data1,
  output logic [DATA_W-1:0] RD_out1,
  output logic [DATA_W-1:0] RD_out2,
  output logic              RD_valid1,
  output logic              RD_valid2,
  output logic              wr_success0,
  output logic              wr_success1,
  output logic              wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic [DATA_W-1:0] rd_out1_q, rd_out1_d;
  logic [DATA_W-1:0] rd_out2_q, rd_out2_d;
  logic              rd_valid1_q, rd_valid1_d;
  logic              rd_valid2_q, rd_valid2_d;
  logic              wr_success0_q, wr_success0_d;
  logic              wr_success1_q, wr_success1_d;
  logic              wr_conflict_q, wr_conflict_d;

  logic              collide;

  // Port 1 is applied first so port 0 wins when both target the same entry.
  always_comb begin
    collide = WR_en0 && WR_en1 && (WR_addr0 == WR_addr1);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (WR_en1) begin
      mem_d[WR_addr1] = WR_data1;
    end
    if (WR_en0) begin
      mem_d[WR_addr0] = WR_data0;
    end
    wr_success0_d = WR_en0;
    wr_success1_d = WR_en1 && !collide;
    wr_conflict_d = collide;
  end

  // Read ports: load on enable, otherwise hold data and drop valid.
  always_comb begin
    rd_out1_d   = rd_out1_q;
    rd_out2_d   = rd_out2_q;
    rd_valid1_d = RD_en1;
    rd_valid2_d = RD_en2;
`ifdef RD_BYPASS_EN
    // Write-first: forward same-edge write data, port 0 taking precedence.
    if (RD_en1) begin
      if (WR_en0 && (WR_addr0 == RD_addr1)) begin
        rd_out1_d = WR_data0;
      end else if (WR_en1 && (WR_addr1 == RD_addr1)) begin
        rd_out1_d = WR_data1;
      end else begin
        rd_out1_d = mem_q[RD_addr1];
      end
    end
    if (RD_en2) begin
      if (WR_en0 && (WR_addr0 == RD_addr2)) begin
        rd_out2_d = WR_data0;
      end else if (WR_en1 && (WR_addr1 == RD_addr2)) begin
        rd_out2_d = WR_data1;
      end else begin
        rd_out2_d = mem_q[RD_addr2];
      end
    end
`else
    // Read-first: always return the contents held before this edge.
    if (RD_en1) begin
      rd_out1_d = mem_q[RD_addr1];
    end
    if (RD_en2) begin
      rd_out2_d = mem_q[RD_addr2];
    end
`endif
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Output flops: read data/valid and write status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_out1_q     <= '0;
      rd_out2_q     <= '0;
      rd_valid1_q   <= 1'b0;
      rd_valid2_q   <= 1'b0;
      wr_success0_q <= 1'b0;
      wr_success1_q <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      rd_out1_q     <= rd_out1_d;
      rd_out2_q     <= rd_out2_d;
      rd_valid1_q   <= rd_valid1_d;
      rd_valid2_q   <= rd_valid2_d;
      wr_success0_q <= wr_success0_d;
      wr_success1_q <= wr_success1_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign RD_out1     = rd_out1_q;
  assign RD_out2     = rd_out2_q;
  assign RD_valid1   = rd_valid1_q;
  assign RD_valid2   = rd_valid2_q;
  assign wr_success0 = wr_success0_q;
  assign wr_success1 = wr_success1_q;
  assign wr_conflict = wr_conflict_q;

endmodule
